// File: rtl/sha1_gpio_pkg.sv
// Shared types and constants for the SHA1 GPIO status transmitter.
// Optional feature macro: SHA1_GPIO_DIGEST_STREAM_EN (adds the STREAM state).
package sha1_gpio_pkg;

  localparam int unsigned DIGEST_W   = 160;
  localparam int unsigned HALF_W     = 16;
  localparam int unsigned NUM_HALVES = DIGEST_W / HALF_W;
  localparam int unsigned IDX_W      = 4;

  localparam logic [HALF_W-1:0] CODE_START = 16'hFEED;
  localparam logic [HALF_W-1:0] CODE_PASS  = 16'hDEAD;
  localparam logic [HALF_W-1:0] CODE_FAIL  = 16'hBAD0;
  localparam logic [HALF_W-1:0] CODE_TMO   = 16'hBAD1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WAIT,
    ST_CMP,
`ifdef SHA1_GPIO_DIGEST_STREAM_EN
    ST_STREAM,
`endif
    ST_RESULT
  } state_e;

  // Larger of two parameters; sizes the shared hold/timeout counter.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sha1_gpio_hold_cnt.sv
// Loadable saturating down-counter with a registered "last cycle" flag.
// Ports: clk/rst (async active-high), load_i + load_val_i (load has priority),
//        en_i (decrement), done_o (high while the count is at 1 or 0).
module sha1_gpio_hold_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;

  // Next count; done tracks "the current cycle is the last one"
  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (load_i) begin
      cnt_d  = load_val_i;
      done_d = (load_val_i <= W'(1));
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d  = cnt_q - W'(1);
      done_d = (cnt_q <= W'(2));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;

endmodule

// File: rtl/sha1_gpio_status_tx.sv
// Drives the 16-bit check-code field on mprj_io[31:16]: start marker 0xFEED,
// then a verdict (0xDEAD match / 0xBAD0 mismatch / 0xBAD1 timeout) derived
// from the SHA1 digest versus an expected digest.
// Ports: wb_clk_i, wb_rst_i (async active-high), start_i, digest_valid_i,
//        digest_i[159:0], expected_i[159:0], io_out[15:0], io_oeb[15:0],
//        busy_o, done_o, pass_o.
// Optional macro SHA1_GPIO_DIGEST_STREAM_EN: stream the captured digest as
// ten halfwords between compare and verdict.
module sha1_gpio_status_tx
  import sha1_gpio_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                start_i,
  input  logic                digest_valid_i,
  input  logic [DIGEST_W-1:0] digest_i,
  input  logic [DIGEST_W-1:0] expected_i,
  output logic [HALF_W-1:0]   io_out,
  output logic [HALF_W-1:0]   io_oeb,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] TMO_LD  = CNT_W'(TIMEOUT_CYCLES);

  state_e              state_q, state_d;
  logic [HALF_W-1:0]   io_out_q, io_out_d;
  logic [HALF_W-1:0]   io_oeb_q, io_oeb_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [DIGEST_W-1:0] cap_q, cap_d;
  logic                capf_q, capf_d;
  logic                match_c;
  logic                cnt_load, cnt_en, cnt_done;
  logic [CNT_W-1:0]    cnt_val;
`ifdef SHA1_GPIO_DIGEST_STREAM_EN
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    nidx_c;
  logic                mreg_q, mreg_d;
`endif

  assign match_c = (cap_q == expected_i);

  // One counter serves both the hold window and the timeout window
  sha1_gpio_hold_cnt #(.W(CNT_W)) u_cnt (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_val),
    .en_i       (cnt_en),
    .done_o     (cnt_done)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    io_out_d = io_out_q;
    io_oeb_d = io_oeb_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    cap_d    = cap_q;
    capf_d   = capf_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_val  = HOLD_LD;
`ifdef SHA1_GPIO_DIGEST_STREAM_EN
    idx_d    = idx_q;
    mreg_d   = mreg_q;
    nidx_c   = idx_q + IDX_W'(1);
`endif

    case (state_q)
      ST_IDLE, ST_RESULT: begin
        if (start_i) begin
          state_d  = ST_HOLD;
          io_out_d = CODE_START;
          io_oeb_d = '0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          capf_d   = 1'b0;
          cnt_load = 1'b1;
        end
      end

      ST_HOLD: begin
        cnt_en = 1'b1;
        // First pulse wins; later pulses leave the capture untouched
        if (digest_valid_i && !capf_q) begin
          cap_d  = digest_i;
          capf_d = 1'b1;
        end
        if (cnt_done) begin
          if (capf_q || digest_valid_i) begin
            state_d = ST_CMP;
          end else begin
            state_d  = ST_WAIT;
            cnt_load = 1'b1;
            cnt_val  = TMO_LD;
          end
        end
      end

      ST_WAIT: begin
        cnt_en = 1'b1;
        // A digest arriving on the expiry cycle takes precedence
        if (digest_valid_i) begin
          cap_d   = digest_i;
          capf_d  = 1'b1;
          state_d = ST_CMP;
        end else if (cnt_done) begin
          state_d  = ST_RESULT;
          io_out_d = CODE_TMO;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          pass_d   = 1'b0;
        end
      end

      ST_CMP: begin
`ifdef SHA1_GPIO_DIGEST_STREAM_EN
        state_d  = ST_STREAM;
        mreg_d   = match_c;
        idx_d    = '0;
        io_out_d = cap_q[DIGEST_W-1 -: HALF_W];
        cnt_load = 1'b1;
`else
        state_d  = ST_RESULT;
        io_out_d = match_c ? CODE_PASS : CODE_FAIL;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        pass_d   = match_c;
`endif
      end

`ifdef SHA1_GPIO_DIGEST_STREAM_EN
      ST_STREAM: begin
        cnt_en = 1'b1;
        if (cnt_done) begin
          if (idx_q == IDX_W'(NUM_HALVES - 1)) begin
            state_d  = ST_RESULT;
            io_out_d = mreg_q ? CODE_PASS : CODE_FAIL;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            pass_d   = mreg_q;
          end else begin
            idx_d    = nidx_c;
            io_out_d = cap_q[(DIGEST_W - 1) - HALF_W * int'(nidx_c) -: HALF_W];
            cnt_load = 1'b1;
          end
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q  <= ST_IDLE;
      io_out_q <= '0;
      io_oeb_q <= '1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      cap_q    <= '0;
      capf_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      io_out_q <= io_out_d;
      io_oeb_q <= io_oeb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      cap_q    <= cap_d;
      capf_q   <= capf_d;
    end
  end

`ifdef SHA1_GPIO_DIGEST_STREAM_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      idx_q  <= '0;
      mreg_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      mreg_q <= mreg_d;
    end
  end
`endif

  assign io_out = io_out_q;
  assign io_oeb = io_oeb_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign pass_o = pass_q;

endmodule
